// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundles the signals between the multicycle sequencer and the 16-bit
//   datapath/memory.
//   master : the sequencer. It receives run/opcode/mem_ready and drives the
//            control lines, debug state and the perf counters.
//   slave  : the datapath side. It drives run/opcode/mem_ready and receives
//            the controls.
interface multicycle_control_if;
  logic        run;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic [1:0]  PCSource;
  logic [1:0]  ALUOp;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        RegWrite;
  logic        RegDst;
  logic [3:0]  state;
  logic        halted;
  logic        fault;
  logic [15:0] cycle_count;
  logic [15:0] instr_count;

  modport master (
    input  run, opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           state, halted, fault, cycle_count, instr_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
           state, halted, fault, cycle_count, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencer for the 16-bit multicycle datapath. It steps through
//   fetch / decode / execute / memory / writeback and drives the memory,
//   ALU, PC and register-file select lines. Memory states stall on
//   mem_ready, and a stall that lasts WAIT_LIMIT cycles ends in FAULT. An
//   illegal opcode also ends in FAULT. HALT and FAULT are left only
//   through reset.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high
//   ctrl   - multicycle_control_if.master (run/opcode/mem_ready in,
//            control lines, state, halted, fault, cycle_count,
//            instr_count out)
// Parameters:
//   WAIT_LIMIT - consecutive stall cycles that cause FAULT. 0 disables
//                the timeout. Values 0..255.
// Build option:
//   CTRL_PERF_EN - when defined, cycle_count and instr_count are real
//                  counters. Otherwise both outputs read 0.
module multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_control_if.master  ctrl
);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,  FETCH    = 4'd1,  DECODE = 4'd2,  MEMADDR = 4'd3,
    MEM_READ  = 4'd4,  WB_MEM   = 4'd5,  MEM_WRITE = 4'd6, EXEC_R = 4'd7,
    WB_R      = 4'd8,  BRANCH   = 4'd9,  JUMP   = 4'd10, HALT    = 4'd11,
    FAULT     = 4'd12
  } stateT;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_J    = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);

  stateT      stateReg, stateNext;
  logic [7:0] waitReg, waitNext;
  logic       memState;
  logic       stalling;
  logic       afterDone;

  // Next state after a finished instruction.
  assign afterDone = ctrl.run;
  assign memState  = (stateReg == FETCH) || (stateReg == MEM_READ) ||
                     (stateReg == MEM_WRITE);
  assign stalling  = memState && !ctrl.mem_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
      waitReg  <= 8'd0;
    end else begin
      stateReg <= stateNext;
      waitReg  <= waitNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:      if (ctrl.run) stateNext = FETCH;
      FETCH:     if (ctrl.mem_ready) stateNext = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_R:          stateNext = EXEC_R;
          OP_LW, OP_SW:  stateNext = MEMADDR;
          OP_BEQ:        stateNext = BRANCH;
          OP_J:          stateNext = JUMP;
          OP_HALT:       stateNext = HALT;
          default:       stateNext = FAULT;
        endcase
      end
      // The IR is reread here. If it no longer holds a load/store, the
      // instruction cannot complete, so it is treated as a fault.
      MEMADDR: begin
        if (ctrl.opcode == OP_LW)      stateNext = MEM_READ;
        else if (ctrl.opcode == OP_SW) stateNext = MEM_WRITE;
        else                           stateNext = FAULT;
      end
      MEM_READ:  if (ctrl.mem_ready) stateNext = WB_MEM;
      MEM_WRITE: if (ctrl.mem_ready) stateNext = afterDone ? FETCH : IDLE;
      EXEC_R:    stateNext = WB_R;
      WB_MEM, WB_R, BRANCH, JUMP:
                 stateNext = afterDone ? FETCH : IDLE;
      HALT:      stateNext = HALT;
      FAULT:     stateNext = FAULT;
      default:   stateNext = FAULT;
    endcase
    // Timeout: this stall cycle brings the count up to the limit. A
    // mem_ready in the same cycle clears stalling, so completion wins.
    if (stalling && (LIMIT != 8'd0) && ((waitReg + 8'd1) == LIMIT))
      stateNext = FAULT;
  end

  always_comb begin
    waitNext = waitReg;
    if (stateNext != stateReg) waitNext = 8'd0;
    else if (stalling)         waitNext = waitReg + 8'd1;
  end

  // Moore decode. The only Mealy terms are PC/IR loads in FETCH, which
  // follow mem_ready so the PC does not advance during a stalled fetch.
  always_comb begin
    ctrl.PCWrite     = 1'b0;
    ctrl.PCWriteCond = 1'b0;
    ctrl.IorD        = 1'b0;
    ctrl.MemRead     = 1'b0;
    ctrl.MemWrite    = 1'b0;
    ctrl.IRWrite     = 1'b0;
    ctrl.MemtoReg    = 1'b0;
    ctrl.PCSource    = 2'b00;
    ctrl.ALUOp       = 2'b00;
    ctrl.ALUSrcA     = 1'b0;
    ctrl.ALUSrcB     = 2'b00;
    ctrl.RegWrite    = 1'b0;
    ctrl.RegDst      = 1'b0;
    ctrl.halted      = 1'b0;
    ctrl.fault       = 1'b0;
    case (stateReg)
      FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = 2'b01;
        ctrl.PCWrite = ctrl.mem_ready;
        ctrl.IRWrite = ctrl.mem_ready;
      end
      DECODE:    ctrl.ALUSrcB = 2'b11;
      MEMADDR: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
      end
      WB_MEM: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
      end
      EXEC_R: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUOp   = 2'b10;
      end
      WB_R: begin
        ctrl.RegWrite = 1'b1;
        ctrl.RegDst   = 1'b1;
      end
      BRANCH: begin
        ctrl.ALUSrcA     = 1'b1;
        ctrl.ALUOp       = 2'b01;
        ctrl.PCWriteCond = 1'b1;
        ctrl.PCSource    = 2'b01;
      end
      JUMP: begin
        ctrl.PCWrite  = 1'b1;
        ctrl.PCSource = 2'b10;
      end
      HALT:    ctrl.halted = 1'b1;
      FAULT:   ctrl.fault  = 1'b1;
      default: ;
    endcase
  end

  assign ctrl.state = stateReg;

`ifdef CTRL_PERF_EN
  logic [15:0] cycleReg, instrReg;
  logic        retiring;

  // An instruction retires on the edge that leaves its final state for
  // FETCH. HALT counts as retired when it is entered.
  assign retiring = ((stateNext == FETCH) &&
                     ((stateReg == WB_MEM) || (stateReg == WB_R) ||
                      (stateReg == BRANCH) || (stateReg == JUMP) ||
                      (stateReg == MEM_WRITE))) ||
                    ((stateNext == HALT) && (stateReg != HALT));

  always_ff @(posedge clock) begin
    if (reset) begin
      cycleReg <= 16'd0;
      instrReg <= 16'd0;
    end else begin
      if ((stateReg != IDLE) && (stateReg != HALT) && (stateReg != FAULT))
        cycleReg <= cycleReg + 16'd1;
      if (retiring)
        instrReg <= instrReg + 16'd1;
    end
  end

  assign ctrl.cycle_count = cycleReg;
  assign ctrl.instr_count = instrReg;
`else
  assign ctrl.cycle_count = 16'd0;
  assign ctrl.instr_count = 16'd0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control. The DUT is built with
//   WAIT_LIMIT=4. The bench applies a directed vector table, a perf-counter
//   sequence and a long random run. A behavioural instruction-plan model
//   predicts the state, control lines and counters.
module tb_multicycle_control;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_control_if bus ();

  multicycle_control #(.WAIT_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (bus)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
    logic [1:0] pcsrc, aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       regw, regdst, hlt, flt;
  } ctrl_t;

  ctrl_t actCtrl;
  assign actCtrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.PCSource,
                    bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite,
                    bus.RegDst, bus.halted, bus.fault};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Control lines expected in each state, taken from the state descriptions.
  function automatic ctrl_t expCtrl(input int s, input logic rdy);
    ctrl_t c = '0;
    case (s)
      1:  begin c.mrd = 1; c.srcb = 2'b01; c.pcw = rdy; c.irw = rdy; end
      2:  c.srcb = 2'b11;
      3:  begin c.srca = 1; c.srcb = 2'b10; end
      4:  begin c.mrd = 1; c.iord = 1; end
      5:  begin c.regw = 1; c.m2r = 1; end
      6:  begin c.mwr = 1; c.iord = 1; end
      7:  begin c.srca = 1; c.aluop = 2'b10; end
      8:  begin c.regw = 1; c.regdst = 1; end
      9:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      10: begin c.pcw = 1; c.pcsrc = 2'b10; end
      11: c.hlt = 1;
      12: c.flt = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Behavioural model. DECODE loads the list of states left in the
  // instruction. Memory states wait for ready, and an empty list means
  // the instruction has finished.
  int          mState = 0;
  int          mWait  = 0;
  int          plan[$];
  logic [15:0] mCycle = 16'd0;
  logic [15:0] mInstr = 16'd0;

  task automatic modelStep(input logic rst, input logic run,
                           input logic [3:0] op, input logic rdy);
    int  nxt;
    bit  done;
    bit  isMem;
    if (rst) begin
      mState = 0; mWait = 0; plan.delete(); mCycle = 0; mInstr = 0;
      return;
    end
    nxt   = mState;
    done  = 0;
    isMem = (mState == 1) || (mState == 4) || (mState == 6);
    case (mState)
      0: if (run) nxt = 1;
      1: if (rdy) nxt = 2;
      2: begin
        plan.delete();
        case (op)
          4'h0: plan = '{7, 8};
          4'h4: plan = '{3, 4, 5};
          4'h5: plan = '{3, 6};
          4'h6: plan = '{9};
          4'h7: plan = '{10};
          4'hF: plan = '{11};
          default: plan = '{12};
        endcase
        nxt = plan.pop_front();
      end
      3: begin
        plan.delete();
        if (op == 4'h4)      plan = '{4, 5};
        else if (op == 4'h5) plan = '{6};
        else                 plan = '{12};
        nxt = plan.pop_front();
      end
      11, 12: nxt = mState;
      default: begin
        if (!isMem || rdy) begin
          if (plan.size() > 0) nxt = plan.pop_front();
          else begin done = 1; nxt = run ? 1 : 0; end
        end
      end
    endcase
    if (isMem && !rdy) begin
      mWait++;
      if (LIMIT != 0 && mWait == LIMIT) nxt = 12;
    end
    if (mState != 0 && mState != 11 && mState != 12) mCycle++;
    if ((done && nxt == 1) || (nxt == 11 && mState != 11)) mInstr++;
    if (nxt != mState) mWait = 0;
    mState = nxt;
  endtask

  function automatic int expPerf(input logic [15:0] v);
`ifdef CTRL_PERF_EN
    return int'(v);
`else
    return 0 * int'(v);
`endif
  endfunction

  typedef struct {
    logic       rst, run;
    logic [3:0] op;
    logic       rdy;
    int         expState;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic rst, input logic run, input logic [3:0] op,
                      input logic rdy, input int s);
    vec_t v;
    v.rst = rst; v.run = run; v.op = op; v.rdy = rdy; v.expState = s;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic run, input logic [3:0] op,
                       input logic rdy);
    reset = rst; bus.run = run; bus.opcode = op; bus.mem_ready = rdy;
  endtask

  task automatic tick(input logic rst, input logic run, input logic [3:0] op,
                      input logic rdy);
    @(posedge clock);
    modelStep(rst, run, op, rdy);
    #1;
  endtask

  initial begin
    // R-type: 0,1,2,7,8,1
    addv(0,1,4'h0,1,0); addv(0,1,4'h0,1,1); addv(0,1,4'h0,1,2);
    addv(0,1,4'h0,1,7); addv(0,1,4'h0,1,8);
    // LW with three stall cycles in MEM_READ
    addv(0,1,4'h4,1,1); addv(0,1,4'h4,1,2); addv(0,1,4'h4,1,3);
    addv(0,1,4'h4,0,4); addv(0,1,4'h4,0,4); addv(0,1,4'h4,0,4);
    addv(0,1,4'h4,1,4); addv(0,1,4'h4,1,5);
    // SW with one stall cycle
    addv(0,1,4'h5,1,1); addv(0,1,4'h5,1,2); addv(0,1,4'h5,1,3);
    addv(0,1,4'h5,0,6); addv(0,1,4'h5,1,6);
    // BEQ, then J with run dropped during JUMP
    addv(0,1,4'h6,1,1); addv(0,1,4'h6,1,2); addv(0,1,4'h6,1,9);
    addv(0,1,4'h7,1,1); addv(0,1,4'h7,1,2); addv(0,0,4'h7,1,10);
    addv(0,0,4'h7,1,0); addv(0,1,4'h3,1,0);
    // Illegal opcode goes to FAULT, which is absorbing until reset
    addv(0,1,4'h3,1,1); addv(0,1,4'h3,1,2); addv(0,0,4'h3,1,12);
    addv(0,1,4'h3,1,12); addv(1,1,4'h3,1,12);
    // HALT ignores run; reset returns to IDLE
    addv(0,1,4'hF,1,0); addv(0,1,4'hF,1,1); addv(0,1,4'hF,1,2);
    addv(0,0,4'hF,1,11); addv(0,1,4'hF,1,11); addv(1,1,4'hF,1,11);
    // Fetch timeout after four stall cycles
    addv(0,1,4'h0,1,0);
    addv(0,1,4'h0,0,1); addv(0,1,4'h0,0,1); addv(0,1,4'h0,0,1);
    addv(0,1,4'h0,0,1); addv(0,1,4'h0,1,12); addv(1,1,4'h0,1,12);
    // Ready in the same cycle as the limit: completion wins
    addv(0,1,4'h0,1,0);
    addv(0,1,4'h0,0,1); addv(0,1,4'h0,0,1); addv(0,1,4'h0,0,1);
    addv(0,1,4'h0,1,1); addv(0,1,4'h0,1,2); addv(0,1,4'h0,1,7);
    // Reset in WB_R aborts the instruction with no strobes afterwards
    addv(1,1,4'h0,1,8); addv(0,0,4'h0,1,0);

    drive(1, 0, 4'h0, 0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", int'(bus.state), 0);
    chk("reset_ctrl", int'(actCtrl), 0);
    chk("reset_cycles", int'(bus.cycle_count), 0);
    chk("reset_instrs", int'(bus.instr_count), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].rdy);
      #4;
      $display("vec %0d: rst=%0b run=%0b op=%h rdy=%0b state=%0d exp=%0d",
               i, vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].rdy,
               bus.state, vecs[i].expState);
      chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].expState);
      chk($sformatf("vec%0d_ctrl", i), int'(actCtrl),
          int'(expCtrl(vecs[i].expState, vecs[i].rdy)));
      tick(vecs[i].rst, vecs[i].run, vecs[i].op, vecs[i].rdy);
    end

    // Perf: three R-type instructions then HALT, with memory always ready
    drive(1, 0, 4'h0, 1);
    tick(1, 0, 4'h0, 1);
    for (int c = 0; c < 18; c++) begin
      drive(0, 1, (c >= 13) ? 4'hF : 4'h0, 1);
      tick(0, 1, (c >= 13) ? 4'hF : 4'h0, 1);
    end
    #4;
    $display("perf: state=%0d cycles=%0d instrs=%0d", bus.state,
             bus.cycle_count, bus.instr_count);
    chk("perf_state", int'(bus.state), 11);
    chk("perf_halted", int'(bus.halted), 1);
`ifdef CTRL_PERF_EN
    chk("perf_instrs", int'(bus.instr_count), 4);
    chk("perf_cycles", int'(bus.cycle_count), 14);
`else
    chk("perf_instrs", int'(bus.instr_count), 0);
    chk("perf_cycles", int'(bus.cycle_count), 0);
`endif
    @(posedge clock); #1;

    // Random run against the model
    begin
      logic       rRst, rRun, rRdy;
      logic [3:0] rOp;
      int         pick;
      rOp = 4'h0;
      for (int n = 0; n < 4000; n++) begin
        rRst = ($urandom_range(0, 199) == 0) ||
               ((mState == 11 || mState == 12) && $urandom_range(0, 3) == 0);
        rRun = ($urandom_range(0, 3) != 0);
        rRdy = ($urandom_range(0, 2) != 0);
        if (mState == 0 || mState == 1) begin
          pick = $urandom_range(0, 12);
          case (pick)
            0, 1:   rOp = 4'h0;
            2, 3:   rOp = 4'h4;
            4, 5:   rOp = 4'h5;
            6, 7:   rOp = 4'h6;
            8, 9:   rOp = 4'h7;
            10:     rOp = 4'hF;
            11:     rOp = 4'h3;
            default: rOp = 4'($urandom_range(0, 15));
          endcase
        end
        drive(rRst, rRun, rOp, rRdy);
        #4;
        chk("rnd_state", int'(bus.state), mState);
        chk("rnd_ctrl", int'(actCtrl), int'(expCtrl(mState, rRdy)));
        chk("rnd_cycles", int'(bus.cycle_count), expPerf(mCycle));
        chk("rnd_instrs", int'(bus.instr_count), expPerf(mInstr));
        if (rRst)
          $display("rnd %0d: reset applied in state %0d", n, mState);
        tick(rRst, rRun, rOp, rRdy);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the 16-bit datapath (instruction fields opcode[15:12], rs/rt/rd, funct[2:0], imm[5:0]).
- Moore FSM: steps fetch, decode, execute, memory and writeback over several cycles.
- Drives the shared memory, ALU, PC and register-file select lines.
- Stalls on a memory ready handshake; faults on memory timeout or illegal opcode.

Parameters:
WAIT_LIMIT, 15, max consecutive stall cycles in a memory state before FAULT; 0 disables timeout (max 255)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
run  input  1  permits leaving IDLE and starting a new fetch
opcode  input  4  IR[15:12], valid from DECODE onward
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU Zero in datapath
IorD  output  1  memory address: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  writeback source: 1=MDR, 0=ALUOut
PCSource  output  2  00=ALU, 01=ALUOut (branch target), 10=jump target
ALUOp  output  2  00=add, 01=sub, 10=use funct
ALUSrcA  output  1  0=PC, 1=rs data
ALUSrcB  output  2  00=rt data, 01=const 1, 10=sign-ext imm, 11=sign-ext imm (branch offset)
RegWrite  output  1  register-file write enable
RegDst  output  1  1=rd, 0=rt
state  output  4  current state encoding, debug
halted  output  1  high in HALT
fault  output  1  high in FAULT

Behaviour:
- Opcodes: 0000 R-type, 0100 LW, 0101 SW, 0110 BEQ, 0111 J, 1111 HALT; all others illegal.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEM_READ=4, WB_MEM=5, MEM_WRITE=6, EXEC_R=7, WB_R=8, BRANCH=9, JUMP=10, HALT=11, FAULT=12.
- Outputs are decoded from state only. Exception: PCWrite and IRWrite in FETCH equal mem_ready. Any signal not listed for a state is 0.
- Reset: state=IDLE, every output 0, wait counter 0. Reset asserted mid-instruction aborts it, with no strobes in the following cycle.
- IDLE: advance to FETCH when run=1.
- FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11, ALUOp=00. Next state by opcode: R→EXEC_R, LW/SW→MEMADDR, BEQ→BRANCH, J→JUMP, HALT→HALT, illegal→FAULT.
- MEMADDR: ALUSrcA=1, ALUSrcB=10. Next: LW→MEM_READ, SW→MEM_WRITE (opcode sampled this cycle).
- MEM_READ: MemRead=1, IorD=1. Go to WB_MEM on mem_ready.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0.
- MEM_WRITE: MemWrite=1, IorD=1. Complete on mem_ready.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- WB_R: RegWrite=1, RegDst=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- After WB_MEM, completed MEM_WRITE, WB_R, BRANCH or JUMP: next state is FETCH if run=1, else IDLE.
- Latency with mem_ready held 1: R=4, LW=5, SW=4, BEQ=3, J=3 cycles.
- Wait counter (8-bit):
  - Increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0.
  - Clears on any state change.
  - With WAIT_LIMIT≠0, reaching count==WAIT_LIMIT while mem_ready=0 → FAULT on the next edge.
  - mem_ready=1 on the same cycle the limit is reached: completion wins.
- HALT and FAULT are absorbing; only reset exits them.

Optional Feature:
CTRL_PERF_EN
- Defined: adds outputs cycle_count[15:0] and instr_count[15:0], both reset to 0.
  - cycle_count increments every cycle state≠IDLE/HALT/FAULT.
  - instr_count increments on each transition into FETCH from a completing state, or into HALT.
  - Both wrap 0xFFFF→0.
- Undefined: both ports present, tied to 0; no counter registers.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0000 → state sequence 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in WB_R.
- LW (0100) with mem_ready low 3 cycles in MEM_READ → MEM_READ held 4 cycles with MemRead=1, IorD=1; then WB_MEM with MemtoReg=1.
- WAIT_LIMIT=4, mem_ready=0 in FETCH → FAULT after 4 stall cycles, fault=1, all strobes 0. Repeat with mem_ready=1 on the 4th cycle → DECODE.
- Opcode 0011 → DECODE→FAULT. Opcode 1111 → HALT, halted=1, run toggling has no effect; reset → IDLE.
- BEQ then J with run dropped during JUMP → BRANCH shows PCWriteCond=1, PCSource=01; JUMP shows PCWrite=1, PCSource=10; next state IDLE.
- CTRL_PERF_EN defined: three R-type instructions then HALT with mem_ready=1 → instr_count=4, cycle_count=14.
